// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller BIST: default widths, FSM states,
// march phase encoding and the data pattern generator.
package sram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_e;

  // Bit 0 selects read, bit 1 selects the inverted pattern.
  typedef enum logic [1:0] {
    PH_WR_P = 2'd0,
    PH_RD_P = 2'd1,
    PH_WR_N = 2'd2,
    PH_RD_N = 2'd3
  } phase_e;

  function automatic logic [DEF_DATA_W-1:0] pattern(
    input logic [DEF_ADDR_W-1:0] addr,
    input logic                  invert,
    input logic [DEF_DATA_W-1:0] seed
  );
    logic [DEF_DATA_W-1:0] p;
    p = addr[15:0] ^ {14'b0, addr[17:16]} ^ seed;
    return invert ? ~p : p;
  endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Main-system request port of the SRAM controller; the BIST drives it as master.
interface sram_bist_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_f2s;
  logic              ready;
  logic [DATA_W-1:0] data_s2f;

  modport master (output mem, rw, addr, data_f2s, input ready, data_s2f);
  modport slave  (input mem, rw, addr, data_f2s, output ready, data_s2f);
endinterface

// File: rtl/sram_bist_cmp.sv
// Read-data checker: flags a mismatch and produces the saturating error count.
module sram_bist_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data_s2f,
  input  logic [DATA_W-1:0] expected,
  input  logic [15:0]       err_count,
  output logic              mismatch,
  output logic [15:0]       err_next
);
  always_comb begin
    mismatch = (data_s2f != expected);
    err_next = err_count;
    if (mismatch && (err_count != 16'hFFFF)) err_next = err_count + 16'd1;
  end
endmodule

// File: rtl/sram_bist.sv
// Four-phase march BIST (write P, read P, write ~P, read ~P) over an address
// window, issuing one request per op to the SRAM controller's main port.
module sram_bist
  import sram_pkg::*;
#(
  parameter int               ADDR_W     = DEF_ADDR_W,
  parameter int               DATA_W     = DEF_DATA_W,
  parameter int unsigned      ADDR_FIRST = 0,
  parameter int unsigned      ADDR_LAST  = (2 ** ADDR_W) - 1,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5C3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  sram_bist_if.master       bus
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(ADDR_FIRST);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(ADDR_LAST);

  state_e            state, state_nxt;
  phase_e            phase, phase_nxt;
  logic [ADDR_W-1:0] cur_addr, addr_nxt;
  logic              op_pending;
  logic              start_ok, check_rd;
  logic              mismatch;
  logic [15:0]       err_next;
  logic [DATA_W-1:0] expected;

  assign expected = pattern(cur_addr, phase[1], SEED);

  sram_bist_cmp #(.DATA_W(DATA_W)) u_cmp (
    .data_s2f  (bus.data_s2f),
    .expected  (expected),
    .err_count (err_count),
    .mismatch  (mismatch),
    .err_next  (err_next)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    addr_nxt  = cur_addr;
    phase_nxt = phase;
    start_ok  = 1'b0;
    check_rd  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          addr_nxt  = FIRST_A;
          phase_nxt = PH_WR_P;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ready) begin
          if (op_pending) begin
            check_rd  = phase[0];
            state_nxt = S_NEXT;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_NEXT: begin
        if (cur_addr == LAST_A) begin
          addr_nxt  = FIRST_A;
          phase_nxt = phase_e'(phase + 2'd1);
          state_nxt = (phase == PH_RD_N) ? S_FIN : S_ISSUE;
        end else begin
          addr_nxt  = cur_addr + 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      phase          <= PH_WR_P;
      cur_addr       <= FIRST_A;
      op_pending     <= 1'b0;
      bus.mem        <= 1'b0;
      bus.rw         <= 1'b1;
      bus.addr       <= FIRST_A;
      bus.data_f2s   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      cur_addr <= addr_nxt;
      bus.mem  <= (state_nxt == S_ISSUE);

      // Request fields move only when a new op is launched.
      if (state_nxt == S_ISSUE) begin
        bus.rw       <= phase_nxt[0];
        bus.addr     <= addr_nxt;
        bus.data_f2s <= pattern(addr_nxt, phase_nxt[1], SEED);
        op_pending   <= 1'b1;
      end else if (start_ok || (state == S_WAIT && bus.ready)) begin
        op_pending <= 1'b0;
      end

      if (start_ok) begin
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end

      if (check_rd && mismatch) begin
        err_count <= err_next;
        if (err_count == 16'd0) first_err_addr <= cur_addr;
      end

      if (state == S_FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural controller + 16-word SRAM, protocol monitor,
// table-driven run vectors and checker vectors, plus reset-mid-run sequence.
module tb_sram_bist;
  import sram_pkg::*;

  localparam int          AW      = 18;
  localparam int          DW      = 16;
  localparam logic [15:0] SEED_TB = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ctrl_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          stuck3 = 1'b0;

  always #5 clk = ~clk;

  sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bist #(
    .ADDR_W(AW), .DATA_W(DW), .ADDR_FIRST(0), .ADDR_LAST(15), .SEED(SEED_TB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr), .bus(bus)
  );

  // Standalone checker instance for saturation vectors a short run cannot reach.
  logic [15:0] cmp_data, cmp_exp, cmp_err, cmp_next;
  logic        cmp_mis;
  sram_bist_cmp #(.DATA_W(DW)) u_cmp (
    .data_s2f(cmp_data), .expected(cmp_exp), .err_count(cmp_err),
    .mismatch(cmp_mis), .err_next(cmp_next)
  );

  // Controller model: accepts on mem&ready, busy two cycles, then ready with read data.
  logic [15:0] sram [0:15];
  logic [1:0]  busy_cnt;
  logic        lat_rw;
  logic [3:0]  lat_addr;
  logic [15:0] lat_data;

  always @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      bus.ready    <= 1'b1;
      bus.data_s2f <= '0;
      busy_cnt     <= 2'd0;
    end else if (busy_cnt == 2'd0) begin
      if (bus.mem && bus.ready) begin
        busy_cnt  <= 2'd2;
        bus.ready <= 1'b0;
        lat_rw    <= bus.rw;
        lat_addr  <= bus.addr[3:0];
        lat_data  <= bus.data_f2s;
      end
    end else begin
      busy_cnt <= busy_cnt - 2'd1;
      if (busy_cnt == 2'd1) begin
        bus.ready <= 1'b1;
        if (lat_rw) bus.data_s2f <= stuck3 ? (sram[lat_addr] & 16'hFFF7) : sram[lat_addr];
        else        sram[lat_addr] <= lat_data;
      end
    end
  end

  // Protocol monitor: logs accepted requests and counts handshake violations.
  typedef struct packed {
    logic        rw;
    logic [17:0] addr;
    logic [15:0] data;
  } req_t;
  req_t req_log [0:1023];
  int   acc_total = 0;
  int   viol_total = 0;
  logic mem_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.mem && !bus.ready) viol_total++;
    if (bus.mem && mem_prev)   viol_total++;
    if (bus.mem && bus.ready) begin
      if (acc_total < 1024) req_log[acc_total] = '{bus.rw, bus.addr, bus.data_f2s};
      acc_total++;
    end
    mem_prev = bus.mem;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tb_pat(input int a, input bit inv);
    logic [15:0] p;
    p = 16'(a) ^ SEED_TB;
    return inv ? ~p : p;
  endfunction

  typedef struct {
    bit   stuck;
    int   extra;       // cycle after which a second start pulse is driven (0 = none)
    int   exp_cycles;
    bit   exp_pass;
    int   exp_err;
    int   exp_first;
  } run_t;

  typedef struct {
    logic [15:0] data, exp, err_in;
    logic        exp_mis;
    logic [15:0] exp_next;
  } cmp_vec_t;

  task automatic do_run(input run_t r, input string tag);
    int cycles, base, vbase, seq_err, ph;
    req_t e;
    base    = acc_total;
    vbase   = viol_total;
    stuck3  = r.stuck;
    cycles  = 0;
    seq_err = 0;
    @(negedge clk);
    start = 1'b1;
    while (cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == r.extra);
      if (done) break;
    end
    start = 1'b0;
    check({tag, "_cycles"}, cycles, r.exp_cycles);
    check({tag, "_pass"}, pass, r.exp_pass);
    check({tag, "_err_count"}, err_count, r.exp_err);
    check({tag, "_first_err"}, first_err_addr, r.exp_first);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {busy, done}, 2'b01);
    check({tag, "_accepts"}, acc_total - base, 64);
    check({tag, "_proto_viol"}, viol_total - vbase, 0);
    for (int i = 0; i < 64; i++) begin
      if (base + i < 1024) begin
        e  = req_log[base + i];
        ph = i / 16;
        if (e.addr != 18'(i % 16) || e.rw != ph[0] ||
            (!ph[0] && e.data != tb_pat(i % 16, ph[1])))
          seq_err++;
      end
    end
    check({tag, "_req_seq"}, seq_err, 0);
  endtask

  run_t     runs [5];
  cmp_vec_t cvec [6];

  initial begin
    int base, cyc;
    req_t last;

    // Stuck bit 3: phase 1 fails where a[3]=1 (8..15), phase 3 where a[3]=0 (0..7).
    runs[0] = '{1'b0, 0,   323, 1'b1, 0,  0};
    runs[1] = '{1'b1, 0,   323, 1'b0, 16, 8};
    runs[2] = '{1'b0, 50,  323, 1'b1, 0,  0};
    runs[3] = '{1'b0, 322, 323, 1'b1, 0,  0};
    runs[4] = '{1'b0, 0,   323, 1'b1, 0,  0};

    cvec[0] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 16'h0000};
    cvec[1] = '{16'h1234, 16'h1235, 16'h0000, 1'b1, 16'h0001};
    cvec[2] = '{16'h0000, 16'hA5C3, 16'hFFFE, 1'b1, 16'hFFFF};
    cvec[3] = '{16'h0000, 16'hA5C3, 16'hFFFF, 1'b1, 16'hFFFF};
    cvec[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF};
    cvec[5] = '{16'h8000, 16'h0000, 16'h0007, 1'b1, 16'h0008};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_first_err", first_err_addr, 18'd0);
    check("rst_mem", bus.mem, 1'b0);
    check("rst_rw", bus.rw, 1'b1);
    check("rst_addr", bus.addr, 18'd0);
    check("rst_data_f2s", bus.data_f2s, 16'd0);

    @(negedge clk);
    reset_n    = 1'b1;
    ctrl_rst_n = 1'b1;

    foreach (cvec[i]) begin
      cmp_data = cvec[i].data;
      cmp_exp  = cvec[i].exp;
      cmp_err  = cvec[i].err_in;
      #1;
      check($sformatf("cmp%0d_mismatch", i), cmp_mis, cvec[i].exp_mis);
      check($sformatf("cmp%0d_err_next", i), cmp_next, cvec[i].exp_next);
    end

    foreach (runs[i]) do_run(runs[i], $sformatf("run%0d", i));

    // Reset mid-run at the phase-1 read of address 7 (request index 23).
    base = acc_total;
    stuck3 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (cyc < 1000 && (acc_total - base) < 24) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check("mid_reached", (acc_total - base) >= 24, 1'b1);
    last = req_log[base + 23];
    check("mid_req_rw", last.rw, 1'b1);
    check("mid_req_addr", last.addr, 18'd7);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mem", bus.mem, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rw_addr", {bus.rw, bus.addr}, {1'b1, 18'd0});
    check("mid_rst_err_done", {done, pass, err_count}, 18'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_run(runs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
